// File: rtl/mem_sm_bist.sv
// March-style BIST initiator for an sm_mem write/read port memory: writes a seeded
// address pattern, reads it back on every read port, then repeats with the pattern inverted.
module mem_sm_bist #(
  parameter int NUMRPRT = 2,
  parameter int NUMWPRT = 1,
  parameter int NUMADDR = 1024,
  parameter int BITDATA = 45,
  parameter int BITADDR = 10,
  parameter int FLOPOUT = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [BITDATA-1:0]                  seed,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [15:0]                         err_cnt,
  output logic [BITADDR-1:0]                  fail_adr,
  output logic [NUMWPRT-1:0]                  sm_mem_write,
  output logic [NUMWPRT-1:0][BITADDR-1:0]     sm_mem_wr_adr,
  output logic [NUMWPRT-1:0][BITDATA-1:0]     sm_mem_din,
  output logic [NUMRPRT-1:0]                  sm_mem_read,
  output logic [NUMRPRT-1:0][BITADDR-1:0]     sm_mem_rd_adr,
  input  logic [NUMRPRT-1:0][BITDATA-1:0]     sm_mem_rd_dout,
  output logic [2:0]                          dbg_state
);

  localparam int RDLAT = FLOPOUT + 1;
  // Two spare bits so cnt+k never wraps while probing past the last address.
  localparam int CW = BITADDR + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                              state_q, state_d;
  logic                                phase_q, phase_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [BITDATA-1:0]                  seed_q, seed_d;
  logic [15:0]                         err_q, err_d;
  logic [BITADDR-1:0]                  fail_q, fail_d;
  logic [NUMRPRT-1:0]                  pv_q [RDLAT];
  logic [NUMRPRT-1:0]                  pv_d [RDLAT];
  logic [NUMRPRT-1:0][BITADDR-1:0]     pa_q [RDLAT];
  logic [NUMRPRT-1:0][BITADDR-1:0]     pa_d [RDLAT];
  logic [NUMRPRT-1:0][BITDATA-1:0]     pe_q [RDLAT];
  logic [NUMRPRT-1:0][BITDATA-1:0]     pe_d [RDLAT];
  logic [NUMRPRT-1:0][BITDATA-1:0]     rd_exp;
  logic [NUMRPRT-1:0]                  mism;
  logic [16:0]                         err_sum;
  logic [BITADDR-1:0]                  first_adr;
  logic                                wr_last, rd_last, dr_last, accept;

  function automatic logic [BITDATA-1:0] pat(input logic [BITDATA-1:0] s,
                                             input logic [CW-1:0] a, input logic ph);
    pat = (s ^ BITDATA'(a[BITADDR-1:0])) ^ {BITDATA{ph}};
  endfunction

  assign wr_last = (cnt_q == CW'(NUMADDR - 1));
  assign rd_last = ((cnt_q + CW'(NUMRPRT)) >= CW'(NUMADDR));
  assign dr_last = (cnt_q == CW'(RDLAT - 1));
  assign accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)   state_d = S_WR;
      S_WR:           if (wr_last) state_d = S_RD;
      S_RD:           if (rd_last) state_d = S_DRAIN;
      S_DRAIN:        if (dr_last) state_d = phase_q ? S_DONE : S_WR;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Memory-side strobes are decoded from flopped state/counter only; addresses
  // and data are forced to 0 whenever the matching strobe is low.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    sm_mem_write  = '0;
    sm_mem_wr_adr = '0;
    sm_mem_din    = '0;
    sm_mem_read   = '0;
    sm_mem_rd_adr = '0;
    rd_exp        = '0;
    case (state_q)
      S_WR: begin
        busy             = 1'b1;
        sm_mem_write[0]  = 1'b1;
        sm_mem_wr_adr[0] = BITADDR'(cnt_q);
        sm_mem_din[0]    = pat(seed_q, cnt_q, phase_q);
      end
      S_RD: begin
        busy = 1'b1;
        for (int k = 0; k < NUMRPRT; k++) begin
          if ((cnt_q + CW'(k)) < CW'(NUMADDR)) begin
            sm_mem_read[k]   = 1'b1;
            sm_mem_rd_adr[k] = BITADDR'(cnt_q + CW'(k));
            rd_exp[k]        = pat(seed_q, cnt_q + CW'(k), phase_q);
          end
        end
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass      = done && (err_q == 16'd0);
  assign err_cnt   = err_q;
  assign fail_adr  = fail_q;
  assign dbg_state = state_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    seed_d  = seed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          seed_d  = seed;
        end
      end
      S_WR:    cnt_d = wr_last ? '0 : cnt_q + CW'(1);
      S_RD:    cnt_d = rd_last ? '0 : cnt_q + CW'(NUMRPRT);
      S_DRAIN: begin
        cnt_d = dr_last ? '0 : cnt_q + CW'(1);
        if (dr_last) phase_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Compare pipeline: each issued read retires RDLAT edges later against dout.
  always_comb begin
    pv_d[0] = sm_mem_read;
    pa_d[0] = sm_mem_rd_adr;
    pe_d[0] = rd_exp;
    for (int i = 1; i < RDLAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    for (int k = 0; k < NUMRPRT; k++)
      mism[k] = pv_q[RDLAT-1][k] && (sm_mem_rd_dout[k] !== pe_q[RDLAT-1][k]);
    err_sum   = {1'b0, err_q};
    first_adr = '0;
    // Walk downward so the lowest failing port's address is the one kept.
    for (int k = NUMRPRT - 1; k >= 0; k--) begin
      if (mism[k]) begin
        err_sum   = err_sum + 17'd1;
        first_adr = pa_q[RDLAT-1][k];
      end
    end
    err_d  = err_q;
    fail_d = fail_q;
    if (accept) begin
      err_d  = '0;
      fail_d = '0;
    end else begin
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if ((err_q == 16'd0) && (mism != '0)) fail_d = first_adr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      for (int i = 0; i < RDLAT; i++) begin
        pv_q[i] <= '0;
        pa_q[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      for (int i = 0; i < RDLAT; i++) begin
        pv_q[i] <= pv_d[i];
        pa_q[i] <= pa_d[i];
        pe_q[i] <= pe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_sm_bist.sv
// Bench for mem_sm_bist: two instances (8 words/FLOPOUT=0 and 7 words/FLOPOUT=1)
// each attached to a fault-injectable memory model, results checked against a word-level model.
module tb_mem_sm_bist;

  localparam int BD = 45;
  localparam int BA = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                 start_v [2];
  logic [BD-1:0]        seed_v  [2];
  logic                 busy_w  [2];
  logic                 done_w  [2];
  logic                 pass_w  [2];
  logic [15:0]          err_w   [2];
  logic [BA-1:0]        fail_w  [2];
  logic [0:0]           wr_w    [2];
  logic [0:0][BA-1:0]   wadr_w  [2];
  logic [0:0][BD-1:0]   din_w   [2];
  logic [1:0]           rd_w    [2];
  logic [1:0][BA-1:0]   radr_w  [2];
  logic [1:0][BD-1:0]   dout_w  [2];
  logic [2:0]           dbg_w   [2];

  // Per-word faults: stuck-at-0 mask, stuck-at-1 mask, flip mask (applied on read).
  logic [BD-1:0] s0 [2][8];
  logic [BD-1:0] s1 [2][8];
  logic [BD-1:0] fx [2][8];
  int            lat_v [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_sm_bist #(.NUMRPRT(2), .NUMWPRT(1), .NUMADDR(8), .BITDATA(BD), .BITADDR(BA), .FLOPOUT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .seed(seed_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]), .fail_adr(fail_w[0]),
    .sm_mem_write(wr_w[0]), .sm_mem_wr_adr(wadr_w[0]), .sm_mem_din(din_w[0]),
    .sm_mem_read(rd_w[0]), .sm_mem_rd_adr(radr_w[0]), .sm_mem_rd_dout(dout_w[0]),
    .dbg_state(dbg_w[0])
  );

  mem_sm_bist #(.NUMRPRT(2), .NUMWPRT(1), .NUMADDR(7), .BITDATA(BD), .BITADDR(BA), .FLOPOUT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .seed(seed_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]), .fail_adr(fail_w[1]),
    .sm_mem_write(wr_w[1]), .sm_mem_wr_adr(wadr_w[1]), .sm_mem_din(din_w[1]),
    .sm_mem_read(rd_w[1]), .sm_mem_rd_adr(radr_w[1]), .sm_mem_rd_dout(dout_w[1]),
    .dbg_state(dbg_w[1])
  );

  function automatic logic [BD-1:0] faulty(input int id, input logic [BD-1:0] v, input int a);
    return ((v & ~s0[id][a]) | s1[id][a]) ^ fx[id][a];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [BD-1:0]      mem [8];
    logic [1:0][BD-1:0] r1, r2;
    always @(posedge clk) begin
      if (wr_w[g][0]) mem[wadr_w[g][0][2:0]] <= din_w[g][0];
      for (int k = 0; k < 2; k++)
        if (rd_w[g][k]) r1[k] <= faulty(g, mem[radr_w[g][k][2:0]], int'(radr_w[g][k][2:0]));
      r2 <= r1;
    end
    assign dout_w[g] = (lat_v[g] == 2) ? r2 : r1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) begin
        s0[i][j] = '0;
        s1[i][j] = '0;
        fx[i][j] = '0;
      end
  endtask

  // Word-level reference: every address read once per phase, phases in order.
  task automatic model(input int id, input int n, input logic [BD-1:0] sd,
                       output int e, output int fa);
    logic [BD-1:0] d;
    e  = 0;
    fa = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < n; a++) begin
        d = sd ^ BD'(a);
        if (ph == 1) d = ~d;
        if (faulty(id, d, a) != d) begin
          if (e == 0) fa = a;
          e++;
        end
      end
    if (e > 65535) e = 65535;
  endtask

  task automatic check_idle(input int id, input string tag);
    check_eq({tag, "_busy"}, busy_w[id], 0);
    check_eq({tag, "_done"}, done_w[id], 0);
    check_eq({tag, "_pass"}, pass_w[id], 0);
    check_eq({tag, "_err"},  err_w[id],  0);
    check_eq({tag, "_fail"}, fail_w[id], 0);
    check_eq({tag, "_strb"}, {wr_w[id], rd_w[id]}, 0);
    check_eq({tag, "_adr"},  |{wadr_w[id], radr_w[id], din_w[id]}, 0);
  endtask

  task automatic run_bist(input int id, input logic [BD-1:0] sd, input bit poke, output int bcyc);
    int guard;
    @(negedge clk);
    seed_v[id]  = sd;
    start_v[id] = 1'b1;
    @(negedge clk);
    start_v[id] = 1'b0;
    seed_v[id]  = ~sd;
    bcyc  = 0;
    guard = 0;
    while (!done_w[id] && guard < 500) begin
      if (busy_w[id]) bcyc++;
      if (poke && guard == 5) start_v[id] = 1'b1;
      if (poke && guard == 6) start_v[id] = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check_eq("run_timeout", guard, 0);
  endtask

  task automatic check_result(input int id, input int n, input int rdlat,
                              input logic [BD-1:0] sd, input int bcyc, input string tag);
    int e, fa;
    model(id, n, sd, e, fa);
    check_eq({tag, "_busy_cyc"}, bcyc, 2 * (n + (n + 1) / 2 + rdlat));
    check_eq({tag, "_done"}, done_w[id], 1);
    check_eq({tag, "_err"},  err_w[id],  e);
    check_eq({tag, "_fail"}, fail_w[id], fa);
    check_eq({tag, "_pass"}, pass_w[id], (e == 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            bc, id, n, a, b, nf, typ;
    logic          quiet;
    logic [BD-1:0] sd;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    seed_v[0]  = '0;
    seed_v[1]  = '0;
    lat_v[0]   = 1;
    lat_v[1]   = 2;
    clear_faults();

    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    rst   = 1'b1;
    quiet = 1'b0;
    repeat (10) begin
      @(negedge clk);
      quiet |= busy_w[0] | done_w[0] | (|wr_w[0]) | (|rd_w[0]);
      quiet |= busy_w[1] | done_w[1] | (|wr_w[1]) | (|rd_w[1]);
    end
    check_eq("idle_quiet", quiet, 0);

    run_bist(0, 45'h1234, 1'b0, bc);
    check_result(0, 8, 1, 45'h1234, bc, "clean");

    s0[0][5] = 45'h8;
    run_bist(0, '0, 1'b0, bc);
    check_result(0, 8, 1, '0, bc, "stuck");
    check_eq("stuck_adr5", fail_w[0], 5);
    clear_faults();

    fx[0][2] = 45'h1;
    fx[0][3] = 45'h80;
    run_bist(0, BD'({$urandom(), $urandom()}), 1'b0, bc);
    check_eq("multi_err4", err_w[0], 4);
    check_eq("multi_adr2", fail_w[0], 2);
    clear_faults();

    sd = BD'({$urandom(), $urandom()});
    run_bist(1, sd, 1'b0, bc);
    check_result(1, 7, 2, sd, bc, "lat");

    lat_v[1] = 1;
    run_bist(1, sd, 1'b0, bc);
    check_eq("lat_mis_err", (err_w[1] != 16'd0), 1);
    check_eq("lat_mis_pass", pass_w[1], 0);
    lat_v[1] = 2;

    sd = BD'({$urandom(), $urandom()});
    s1[0][6] = 45'h1000;
    run_bist(0, sd, 1'b1, bc);
    check_result(0, 8, 1, sd, bc, "poke");
    clear_faults();

    fx[0][0] = 45'h1;
    @(negedge clk);
    seed_v[0]  = BD'({$urandom(), $urandom()});
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (21) @(negedge clk);
    check_eq("pre_abort_err", err_w[0], 1);
    check_eq("pre_abort_rd", (rd_w[0] != 2'b00), 1);
    rst = 1'b0;
    #1;
    check_idle(0, "abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_faults();
    sd = BD'({$urandom(), $urandom()});
    run_bist(0, sd, 1'b1, bc);
    check_result(0, 8, 1, sd, bc, "restart");

    for (int it = 0; it < 8; it++) begin
      id = it % 2;
      n  = (id == 1) ? 7 : 8;
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        a   = $urandom_range(0, n - 1);
        b   = $urandom_range(0, BD - 1);
        typ = $urandom_range(0, 2);
        if (typ == 0)      s0[id][a][b] = 1'b1;
        else if (typ == 1) s1[id][a][b] = 1'b1;
        else               fx[id][a][b] = 1'b1;
      end
      sd = BD'({$urandom(), $urandom()});
      run_bist(id, sd, 1'b0, bc);
      check_result(id, n, (id == 1) ? 2 : 1, sd, bc, $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
